// File: rtl/arbiter_n_to_1_response_pkg.sv
// rtl/arbiter_n_to_1_response_pkg.sv - shared packet/FIFO-status types and round-robin index helper
package arbiter_n_to_1_response_pkg;

  localparam int MAX_MEMORY_RECEIVER = 16;

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
  } MemoryPacketPayload;

  typedef struct packed {
    logic               valid;
    MemoryPacketPayload payload;
  } MemoryPacket;

  typedef struct packed {
    logic rd_en;
  } FIFOStateSignalsInput;

  typedef struct packed {
    logic full;
    logic empty;
    logic valid;
    logic prog_full;
    logic rst_busy;
  } FIFOStateSignalsOutput;

  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/arbiter_n_to_1_response_if.sv
// rtl/arbiter_n_to_1_response_if.sv - producer/consumer bus bundle for the N-to-1 response merger
interface arbiter_n_to_1_response_if #(
  parameter int NUM_MEMORY_RECEIVER = 2
);
  import arbiter_n_to_1_response_pkg::*;

  MemoryPacket           [NUM_MEMORY_RECEIVER-1:0] response_in;
  FIFOStateSignalsInput                            fifo_response_signals_in;
  FIFOStateSignalsOutput [NUM_MEMORY_RECEIVER-1:0] fifo_response_signals_out;
  MemoryPacket                                     response_out;
  logic                                            fifo_setup_signal;

  modport slave (
    input  response_in, fifo_response_signals_in,
    output fifo_response_signals_out, response_out, fifo_setup_signal
  );

  modport master (
    output response_in, fifo_response_signals_in,
    input  fifo_response_signals_out, response_out, fifo_setup_signal
  );

endinterface

// File: rtl/arbiter_n_to_1_response_fifo.sv
// rtl/arbiter_n_to_1_response_fifo.sv - sync FWFT buffer with reset-busy window and prog_full
module xpm_fifo_sync_wrapper #(
  parameter int DEPTH       = 16,
  parameter int PROG_THRESH = 8,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             empty,
  output logic             full,
  output logic             prog_full,
  output logic             wr_rst_busy,
  output logic             rd_rst_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [2:0] BUSY_CYCLES = 3'd4;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    mem_count, total;
  logic             mid_valid, out_valid;
  logic [WIDTH-1:0] mid_data, out_data;
  logic [2:0]       busy_cnt;
  logic             busy, wr_accept, pop, out_load, mid_load;

  // Registered RAM read feeds a mid stage, which feeds the FWFT head register.
  assign busy      = (busy_cnt != 3'd0);
  assign total     = mem_count + CW'(mid_valid) + CW'(out_valid);
  assign wr_accept = wr_en && !busy && (total < CW'(DEPTH));
  assign pop       = rd_en && out_valid;
  assign out_load  = mid_valid && (!out_valid || pop);
  assign mid_load  = (mem_count != '0) && (!mid_valid || out_load);

  always_ff @(posedge clk) begin
    if (srst) begin
      busy_cnt  <= BUSY_CYCLES;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      mid_valid <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (busy) busy_cnt <= busy_cnt - 3'd1;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (mid_load) rd_ptr <= rd_ptr + 1'b1;
      mem_count <= mem_count + CW'(wr_accept) - CW'(mid_load);
      if (mid_load) mid_valid <= 1'b1;
      else if (out_load) mid_valid <= 1'b0;
      if (out_load) out_valid <= 1'b1;
      else if (pop) out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= din;
    if (mid_load) mid_data <= mem[rd_ptr];
    if (out_load) out_data <= mid_data;
  end

  assign dout        = out_data;
  assign valid       = out_valid;
  assign empty       = !out_valid;
  assign full        = busy || (total == CW'(DEPTH));
  assign prog_full   = busy || (total >= CW'(PROG_THRESH));
  assign wr_rst_busy = busy;
  assign rd_rst_busy = busy;

endmodule

// File: rtl/arbiter_n_to_1_response_rr.sv
// rtl/arbiter_n_to_1_response_rr.sv - round-robin arbiter: scan from ptr, one-hot grant and next pointer
module rr_arbiter_n #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic                 en,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] ptr_next
);
  import arbiter_n_to_1_response_pkg::*;

  localparam int IW = $clog2(N);

  always_comb begin
    grant       = '0;
    grant_idx   = ptr;
    grant_valid = 1'b0;
    ptr_next    = ptr;
    for (int k = 0; k < N; k++) begin
      if (en && !grant_valid && req[rr_index(int'(ptr), k, N)]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(rr_index(int'(ptr), k, N));
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
      ptr_next         = IW'(rr_index(int'(grant_idx), 1, N));
    end
  end

endmodule

// File: rtl/arbiter_n_to_1_response.sv
// rtl/arbiter_n_to_1_response.sv - merges N buffered packet streams into one registered output
module arbiter_n_to_1_response #(
  parameter int NUM_MEMORY_RECEIVER = 2,
  parameter int FIFO_DEPTH          = 16,
  parameter int PROG_THRESH         = 8
) (
  input  logic                            ap_clk,
  input  logic                            areset_n,
  arbiter_n_to_1_response_if.slave        resp_if
);
  import arbiter_n_to_1_response_pkg::*;

  localparam int N  = (NUM_MEMORY_RECEIVER > MAX_MEMORY_RECEIVER) ? MAX_MEMORY_RECEIVER
                                                                   : NUM_MEMORY_RECEIVER;
  localparam int IW = $clog2(N);
  localparam int PW = $bits(MemoryPacketPayload);
  localparam FIFOStateSignalsOutput STATUS_RST = '{full: 1'b1, empty: 1'b1, valid: 1'b0,
                                                  prog_full: 1'b1, rst_busy: 1'b1};

  MemoryPacket           [N-1:0] in_q;
  MemoryPacket                   out_q;
  FIFOStateSignalsOutput [N-1:0] status_q;
  logic                          rd_en_q, setup_q, grant_valid;
  logic [1:0]                    srst_sync;
  logic [IW-1:0]                 ptr, ptr_next, grant_idx;
  logic [N-1:0]                  req, grant, wr_busy, rd_busy, b_empty, b_full, b_pfull;
  logic [PW-1:0]                 head [N];

  // Buffers enter reset immediately with areset_n but leave it two edges later.
  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) srst_sync <= 2'b11;
    else           srst_sync <= {srst_sync[0], 1'b0};
  end

  for (genvar i = 0; i < N; i++) begin : g_buf
    xpm_fifo_sync_wrapper #(
      .DEPTH(FIFO_DEPTH), .PROG_THRESH(PROG_THRESH), .WIDTH(PW)
    ) u_fifo (
      .clk(ap_clk), .srst(srst_sync[1]),
      .wr_en(in_q[i].valid), .din(in_q[i].payload),
      .rd_en(grant[i]), .dout(head[i]), .valid(req[i]), .empty(b_empty[i]),
      .full(b_full[i]), .prog_full(b_pfull[i]),
      .wr_rst_busy(wr_busy[i]), .rd_rst_busy(rd_busy[i])
    );
  end

  rr_arbiter_n #(.N(N)) u_rr (
    .req(req), .en(rd_en_q && !setup_q), .ptr(ptr),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .ptr_next(ptr_next)
  );

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      in_q     <= '0;
      out_q    <= '0;
      rd_en_q  <= 1'b0;
      setup_q  <= 1'b1;
      ptr      <= '0;
      for (int i = 0; i < N; i++) status_q[i] <= STATUS_RST;
    end else begin
      for (int i = 0; i < N; i++) begin
        in_q[i]     <= resp_if.response_in[i];
        status_q[i] <= '{full: b_full[i], empty: b_empty[i], valid: req[i],
                         prog_full: b_pfull[i], rst_busy: wr_busy[i] | rd_busy[i]};
      end
      rd_en_q     <= resp_if.fifo_response_signals_in.rd_en;
      setup_q     <= |(wr_busy | rd_busy);
      ptr         <= ptr_next;
      out_q.valid <= grant_valid;
      if (grant_valid) out_q.payload <= head[grant_idx];
    end
  end

  assign resp_if.response_out              = out_q;
  assign resp_if.fifo_response_signals_out = status_q;
  assign resp_if.fifo_setup_signal         = setup_q;

endmodule
